prewish_pattern_blinker: RTL and testbench

Output-side counterpart of the button debouncer on the prewish interconnect: where the debouncer reads a pin and reports a status byte, this block takes an 8-bit pattern byte from a mentor over STB_I/DAT_I and writes it to one LED pin. The pattern is shifted out MSB first, one bit per prescaled period, repeating until replaced or stopped. Each pattern change is reported back on STB_O/DAT_O. It sits beside the debouncer, under the same top-level controller.

---
 rtl/prewish_pattern_blinker_pkg.sv | 8 +
 rtl/prewish_pattern_blinker_prescaler.sv | 28 ++
 rtl/prewish_pattern_blinker.sv | 100 ++++++++++
 tb/tb_prewish_pattern_blinker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/prewish_pattern_blinker_pkg.sv
// Shared constants for the prewish pattern blinker and its prescaler.
package prewish_pattern_blinker_pkg;
   localparam int PREWISH_DAT_W = 8;
   localparam logic [PREWISH_DAT_W-1:0] PREWISH_CMD_STOP = 8'h00;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN = 1'b1;
   localparam logic [2:0] BIT_MSB = 3'd7;
endpackage

// File: rtl/prewish_pattern_blinker_prescaler.sv
// Free-running divider with enable and synchronous clear.
import prewish_pattern_blinker_pkg::*;

module prewish_prescaler #(
   parameter int PRESCALE_BITS = 17
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam logic [PRESCALE_BITS-1:0] ONE = 1;

   logic [PRESCALE_BITS-1:0] cnt;

   assign tick = en && (&cnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + ONE;
      end
   end
endmodule

// File: rtl/prewish_pattern_blinker.sv
// Shifts a command byte out MSB first on one LED pin, repeating,
// with replacements deferred to the pattern boundary.
import prewish_pattern_blinker_pkg::*;

module prewish_pattern_blinker #(
   parameter int PRESCALE_BITS = 17
) (
   input  logic                     CLK_I,
   input  logic                     RST_I,
   input  logic                     STB_I,
   input  logic [PREWISH_DAT_W-1:0] DAT_I,
   output logic                     STB_O,
   output logic [PREWISH_DAT_W-1:0] DAT_O,
   output logic                     o_led,
   output logic                     o_alive
);
   logic [0:0]               state;
   logic [PREWISH_DAT_W-1:0] active;
   logic [PREWISH_DAT_W-1:0] pending;
   logic                     pend_v;
   logic [2:0]               bit_idx;
   logic                     stb_q;
   logic                     alive_q;

   logic running;
   logic tick;
   logic wrap;
   logic stop;
   logic load;
   logic pre_clr;

   assign running = (state == ST_RUN);
   assign stop    = STB_I && (DAT_I == PREWISH_CMD_STOP);
   assign load    = STB_I && (DAT_I != PREWISH_CMD_STOP);
   assign wrap    = tick && (bit_idx == 3'd0);
   assign pre_clr = stop || (!running && load);

   prewish_prescaler #(
      .PRESCALE_BITS(PRESCALE_BITS)
   ) u_pre (
      .clk (CLK_I),
      .rst (RST_I),
      .en  (running),
      .clr (pre_clr),
      .tick(tick)
   );

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state   <= ST_IDLE;
         active  <= '0;
         pending <= '0;
         pend_v  <= 1'b0;
         bit_idx <= BIT_MSB;
         stb_q   <= 1'b0;
         alive_q <= 1'b0;
      end else begin
         stb_q <= 1'b0;
         if (stop) begin
            state   <= ST_IDLE;
            active  <= '0;
            pend_v  <= 1'b0;
            bit_idx <= BIT_MSB;
            stb_q   <= 1'b1;
         end else if (!running) begin
            if (load) begin
               state   <= ST_RUN;
               active  <= DAT_I;
               bit_idx <= BIT_MSB;
               stb_q   <= 1'b1;
            end
         end else begin
            if (tick) begin
               bit_idx <= bit_idx - 3'd1;
            end
            // A write landing on the wrap skips pending entirely.
            if (wrap) begin
               alive_q <= ~alive_q;
               if (load) begin
                  active <= DAT_I;
                  pend_v <= 1'b0;
                  stb_q  <= 1'b1;
               end else if (pend_v) begin
                  active <= pending;
                  pend_v <= 1'b0;
                  stb_q  <= 1'b1;
               end
            end else if (load) begin
               pending <= DAT_I;
               pend_v  <= 1'b1;
            end
         end
      end
   end

   assign STB_O   = stb_q;
   assign DAT_O   = active;
   assign o_led   = running && active[bit_idx];
   assign o_alive = alive_q;
endmodule

// File: tb/tb_prewish_pattern_blinker.sv
// Randomized and directed checks of the pattern blinker
// against a phase-based model.
module tb_prewish_pattern_blinker;
   localparam int PB = 2;
   localparam int P = 4;
   localparam int PAT = 8 * P;

   logic       clk;
   logic       rst;
   logic       stb_i;
   logic [7:0] dat_i;
   logic       stb_o;
   logic [7:0] dat_o;
   logic       led;
   logic       alive;

   int total;
   int bad;

   bit       m_run;
   bit [7:0] m_act;
   bit [7:0] m_pend;
   bit       m_pv;
   int       m_ph;
   bit       m_alive;
   bit       m_stb;

   prewish_pattern_blinker #(
      .PRESCALE_BITS(PB)
   ) dut (
      .CLK_I  (clk),
      .RST_I  (rst),
      .STB_I  (stb_i),
      .DAT_I  (dat_i),
      .STB_O  (stb_o),
      .DAT_O  (dat_o),
      .o_led  (led),
      .o_alive(alive)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [7:0] got,
                      input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, got, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_act = 0; m_pend = 0; m_pv = 0;
      m_ph = 0; m_alive = 0; m_stb = 0;
   endtask

   task automatic model_step(input bit s, input bit [7:0] d);
      m_stb = 0;
      if (s && d == 0) begin
         m_run = 0; m_act = 0; m_pv = 0; m_ph = 0; m_stb = 1;
      end else if (!m_run) begin
         if (s) begin
            m_run = 1; m_act = d; m_ph = 0; m_stb = 1;
         end
      end else if (m_ph == PAT - 1) begin
         m_ph = 0;
         m_alive = !m_alive;
         if (s) begin
            m_act = d; m_pv = 0; m_stb = 1;
         end else if (m_pv) begin
            m_act = m_pend; m_pv = 0; m_stb = 1;
         end
      end else begin
         m_ph++;
         if (s) begin
            m_pend = d; m_pv = 1;
         end
      end
   endtask

   function automatic bit exp_led();
      bit [7:0] a;
      a = m_act;
      return m_run ? a[7 - m_ph / P] : 1'b0;
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step(stb_i, dat_i);
         #1;
         chk("stb_o", {7'd0, stb_o}, {7'd0, m_stb});
         chk("dat_o", dat_o, m_act);
         chk("led", {7'd0, led}, {7'd0, exp_led()});
         chk("alive", {7'd0, alive}, {7'd0, m_alive});
      end
   end

   task automatic wait_ph(input int ph);
      for (int i = 0; i < 4 * PAT; i++) begin
         @(negedge clk);
         if (m_run && m_ph == ph) return;
      end
      chk("wait_ph_timeout", 8'd1, 8'd0);
   endtask

   task automatic pulse(input logic [7:0] d);
      stb_i = 1'b1;
      dat_i = d;
      @(negedge clk);
      stb_i = 1'b0;
      dat_i = 8'h00;
   endtask

   initial begin
      logic [7:0] pat;
      rst = 1'b1;
      stb_i = 1'b0;
      dat_i = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_led", {7'd0, led}, 8'd0);
      chk("rst_dat", dat_o, 8'h00);
      rst = 1'b0;
      @(negedge clk);

      pat = 8'hA5;
      pulse(8'hA5);
      chk("a5_stb", {7'd0, stb_o}, 8'd1);
      chk("a5_dat", dat_o, 8'hA5);
      for (int k = 0; k <= PAT; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) chk("a5_stb_low", {7'd0, stb_o}, 8'd0);
         chk("a5_led", {7'd0, led}, {7'd0, pat[7 - (k % PAT) / P]});
         chk("a5_alive", {7'd0, alive}, (k == PAT) ? 8'd1 : 8'd0);
      end

      wait_ph(9);
      pulse(8'h0F);
      wait_ph(17);
      pulse(8'hF0);
      wait_ph(PAT - 1);
      chk("defer_no_stb", {7'd0, stb_o}, 8'd0);
      @(negedge clk);
      chk("defer_stb", {7'd0, stb_o}, 8'd1);
      chk("defer_dat", dat_o, 8'hF0);
      chk("defer_led", {7'd0, led}, 8'd1);

      wait_ph(PAT - 1);
      pulse(8'h81);
      chk("coin_stb", {7'd0, stb_o}, 8'd1);
      chk("coin_dat", dat_o, 8'h81);
      chk("coin_pv", {7'd0, m_pv}, 8'd0);
      @(negedge clk);
      chk("coin_stb_low", {7'd0, stb_o}, 8'd0);

      wait_ph(10);
      pulse(8'h55);
      wait_ph(13);
      pulse(8'h00);
      chk("stop_led", {7'd0, led}, 8'd0);
      chk("stop_stb", {7'd0, stb_o}, 8'd1);
      chk("stop_dat", dat_o, 8'h00);
      repeat (2 * PAT) @(negedge clk);
      pulse(8'h00);
      chk("stop2_stb", {7'd0, stb_o}, 8'd1);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 29) == 0) begin
            stb_i = 1'b1;
            dat_i = ($urandom_range(0, 9) == 0) ? 8'h00
                    : 8'($urandom_range(1, 255));
         end else begin
            stb_i = 1'b0;
            dat_i = 8'($urandom);
         end
      end
      @(negedge clk);
      stb_i = 1'b0;

      pulse(8'hAA);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_led", {7'd0, led}, 8'd0);
      chk("arst_dat", dat_o, 8'h00);
      chk("arst_stb", {7'd0, stb_o}, 8'd0);
      @(negedge clk);
      pulse(8'h33);
      rst = 1'b0;
      @(negedge clk);
      chk("arst_ign", dat_o, 8'h00);
      pulse(8'h01);
      for (int k = 0; k < PAT; k++) begin
         if (k > 0) @(negedge clk);
         chk("one_led", {7'd0, led}, (k < 28) ? 8'd0 : 8'd1);
      end
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
